// File: rtl/grid_renderer.sv
// Draws the 3x3 tic-tac-toe board as filled squares on the VGA plot interface,
// fetching each cell through a one-cycle-latency read port and outlining the cursor cell.
module grid_renderer #(
    parameter int unsigned CELL_W   = 16,
    parameter int unsigned GAP      = 2,
    parameter int unsigned ORIGIN_X = 56,
    parameter int unsigned ORIGIN_Y = 36,
    parameter logic [2:0]  C_EMPTY  = 3'b111,
    parameter logic [2:0]  C_P1     = 3'b100,
    parameter logic [2:0]  C_P2     = 3'b001,
    parameter logic [2:0]  C_CURSOR = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] cursor,
    output logic [3:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PW    = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int unsigned PITCH = CELL_W + GAP;
    localparam logic [PW-1:0] PX_MAX = PW'(CELL_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAW, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_idx, w_idx_nxt;
    logic [3:0]    r_cur, w_cur_nxt;
    logic [1:0]    r_val, w_val_nxt;
    logic [PW-1:0] r_px, w_px_nxt;
    logic [PW-1:0] r_py, w_py_nxt;
    logic          r_pend, w_pend_nxt;
    logic [1:0]    w_col, w_row;
    logic          w_border;
    logic [7:0]    w_x_nxt;
    logic [6:0]    w_y_nxt;
    logic [2:0]    w_colour_nxt;

    // Next-state and datapath updates
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cur_nxt   = r_cur;
        w_val_nxt   = r_val;
        w_px_nxt    = r_px;
        w_py_nxt    = r_py;
        w_pend_nxt  = r_pend;

        if (start && (r_state != S_IDLE) && (r_state != S_DONE)) begin
            w_pend_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_cur_nxt   = cursor;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                w_val_nxt   = rd_data;
                w_px_nxt    = '0;
                w_py_nxt    = '0;
                w_state_nxt = S_DRAW;
            end
            S_DRAW: begin
                if (r_px == PX_MAX) begin
                    w_px_nxt = '0;
                    if (r_py == PX_MAX) begin
                        if (r_idx == 4'd8) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + 4'd1;
                            w_state_nxt = S_FETCH;
                        end
                    end else begin
                        w_py_nxt = r_py + PW'(1);
                    end
                end else begin
                    w_px_nxt = r_px + PW'(1);
                end
            end
            S_DONE: begin
                // A request seen during the frame (or right now) restarts without idling
                if (r_pend || start) begin
                    w_pend_nxt  = 1'b0;
                    w_cur_nxt   = cursor;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pixel position and colour for the upcoming cycle
    always_comb begin
        w_col = 2'd0;
        w_row = 2'd0;
        case (w_idx_nxt)
            4'd1: begin w_col = 2'd1; w_row = 2'd0; end
            4'd2: begin w_col = 2'd2; w_row = 2'd0; end
            4'd3: begin w_col = 2'd0; w_row = 2'd1; end
            4'd4: begin w_col = 2'd1; w_row = 2'd1; end
            4'd5: begin w_col = 2'd2; w_row = 2'd1; end
            4'd6: begin w_col = 2'd0; w_row = 2'd2; end
            4'd7: begin w_col = 2'd1; w_row = 2'd2; end
            4'd8: begin w_col = 2'd2; w_row = 2'd2; end
            default: begin w_col = 2'd0; w_row = 2'd0; end
        endcase
        w_x_nxt = 8'(ORIGIN_X) + 8'(w_col) * 8'(PITCH) + 8'(w_px_nxt);
        w_y_nxt = 7'(ORIGIN_Y) + 7'(w_row) * 7'(PITCH) + 7'(w_py_nxt);
        w_border = (w_px_nxt == '0) || (w_px_nxt == PX_MAX) ||
                   (w_py_nxt == '0) || (w_py_nxt == PX_MAX);
        if ((w_idx_nxt == w_cur_nxt) && w_border) begin
            w_colour_nxt = C_CURSOR;
        end else begin
            case (w_val_nxt)
                2'd1:    w_colour_nxt = C_P1;
                2'd2:    w_colour_nxt = C_P2;
                default: w_colour_nxt = C_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_cur   <= 4'd0;
            r_val   <= 2'd0;
            r_px    <= '0;
            r_py    <= '0;
            r_pend  <= 1'b0;
            rd_addr <= 4'd0;
            x       <= 8'd0;
            y       <= 7'd0;
            colour  <= 3'd0;
            plot    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cur   <= w_cur_nxt;
            r_val   <= w_val_nxt;
            r_px    <= w_px_nxt;
            r_py    <= w_py_nxt;
            r_pend  <= w_pend_nxt;
            plot    <= (w_state_nxt == S_DRAW);
            busy    <= (w_state_nxt != S_IDLE);
            done    <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_FETCH) begin
                rd_addr <= w_idx_nxt;
            end
            if (w_state_nxt == S_DRAW) begin
                x      <= w_x_nxt;
                y      <= w_y_nxt;
                colour <= w_colour_nxt;
            end
        end
    end

endmodule

// File: doc/grid_renderer.md
# grid_renderer

Reads the 9-cell tic-tac-toe board through a registered read port and draws it as a 3x3 grid of filled squares on the 160x120 VGA adapter plot interface. It sits between the grid storage (the writer of cells) and the VGA adapter. It highlights the cursor cell with a border and reports frame completion to the game FSM. One redraw frame is started per `start` pulse.

## Interface
Parameters:
- `CELL_W`, 16: side of one cell square in pixels; power of two, 2..32.
- `GAP`, 2: empty pixels between adjacent cells.
- `ORIGIN_X`, 56: x of top-left pixel of cell 0.
- `ORIGIN_Y`, 36: y of top-left pixel of cell 0.
- `C_EMPTY`, 3'b111: colour for an empty cell.
- `C_P1`, 3'b100: colour for player one (O).
- `C_P2`, 3'b001: colour for player two (X).
- `C_CURSOR`, 3'b010: colour for the cursor border.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  request one full redraw; sampled on rising edge.
- `cursor`  in  4  cursor cell index 0..8; values 9..15 mean no highlight.
- `rd_addr`  out  4  board read address, 0..8.
- `rd_data`  in  2  cell content for `rd_addr`, valid one cycle after `rd_addr`: 0 empty, 1 P1, 2 P2, 3 treated as empty.
- `x`  out  8  pixel x coordinate.
- `y`  out  7  pixel y coordinate.
- `colour`  out  3  pixel colour.
- `plot`  out  1  pixel write strobe; `x`/`y`/`colour` valid when high.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, FETCH, WAIT, DRAW, DONE.
- IDLE:
  - `busy`=0.
  - On `start`=1: latch `cursor` into `cur_q`, set cell index to 0, and go to FETCH.
- FETCH: drive `rd_addr`=cell index, then go to WAIT.
- WAIT: `rd_addr` is held. At the end of the cycle, latch `rd_data` into `val_q`, clear pixel counters `px` and `py`, and go to DRAW.
- DRAW:
  - `plot`=1 every cycle.
  - `px` increments each cycle. When `px` wraps at `CELL_W`, `py` increments.
  - After pixel (`CELL_W`-1, `CELL_W`-1), go to FETCH for the next cell, or to DONE if the cell index is 8.
- DONE:
  - `done`=1 for one cycle, then go to IDLE.
  - If the pending flag is set, the frame restarts: clear the flag, latch `cursor`, and go directly to FETCH for cell 0.
- Coordinates (col = idx mod 3, row = idx div 3):
  - `x` = `ORIGIN_X` + col*(`CELL_W`+`GAP`) + `px`, truncated to 8 bits.
  - `y` = `ORIGIN_Y` + row*(`CELL_W`+`GAP`) + `py`, truncated to 7 bits.
- Colour:
  - If idx == `cur_q` and the pixel is on the border (`px` or `py` equal to 0 or `CELL_W`-1), colour is `C_CURSOR`.
  - Otherwise: `val_q`=1 gives `C_P1`, `val_q`=2 gives `C_P2`, and 0 or 3 give `C_EMPTY`.
- `start` while `busy`=1 sets a pending flag. It does not disturb the current frame, and multiple requests collapse into one.
- `cursor` changes mid-frame have no effect until the next frame latches it.
- `rd_data` is sampled only in WAIT and is ignored in every other state.

## Timing
- Reset values: `plot`=0, `busy`=0, `done`=0, `rd_addr`=0, `x`=0, `y`=0, `colour`=0, state IDLE, pending flag 0.
- `busy`=1 in FETCH, WAIT, DRAW and DONE.
- `x`, `y`, `colour` and `plot` are valid in the same cycle.
- `start` sampled at edge k:
  - FETCH in cycle k+1.
  - WAIT in cycle k+2.
  - First `plot` in cycle k+3.
- Per cell: 2 + `CELL_W`² cycles. With defaults that is 258 cycles per cell, 2322 cycles per frame, and 2304 plots per frame.
- `done` is high in cycle k+2323 with defaults. The next `start` can be accepted at edge k+2324.
- Reset asserted mid-frame: `plot`, `busy` and `done` drop to 0 immediately. No `done` is issued, and the pending flag is cleared.

## Test plan
- Empty board, `cursor`=9, one `start` pulse:
  - exactly 2304 `plot` cycles, all with colour 3'b111;
  - first pixel (56,36), last pixel (107,87);
  - single `done` pulse 2323 cycles after `start`.
- Board cell 4=1, cell 8=2, `cursor`=0:
  - cell 0 has 60 border pixels at 3'b010 and 196 interior pixels at 3'b111;
  - cell 4 has all 256 pixels at 3'b100 over x 74..89, y 54..69;
  - cell 8 is 3'b001.
- `rd_data`=3 for all cells: every plotted pixel is 3'b111.
- Second `start` pulsed twice during a frame: exactly one further frame, whose FETCH of cell 0 begins the cycle after `done`. Total `done` pulses = 2.
- `cursor` changed from 4 to 0 during cell 2 drawing: border is drawn on cell 4 only; the next frame highlights cell 0.
- Reset asserted at cycle 1000 of a frame:
  - `plot`/`busy` are 0 in that cycle and no `done` follows;
  - after release, a new `start` produces a full 2304-plot frame.
